// File: rtl/vx_assoc_tag_data_access.sv
// N-way set-associative tag/data access stage for one cache bank: lookup, write merge, fill with
// victim eviction, snoop-invalidate, tree-PLRU or round-robin replacement and a sequential flush.
module vx_assoc_tag_data_access #(
    parameter int unsigned NUM_SETS     = 64,
    parameter int unsigned NUM_WAYS     = 4,
    parameter int unsigned LINE_SIZE    = 16,
    parameter int unsigned WORD_SIZE    = 4,
    parameter int unsigned TAG_BITS     = 20,
    parameter int unsigned WRITE_ENABLE = 1,
    parameter int unsigned REPL_POLICY  = 0,
    localparam int unsigned SET_W       = $clog2(NUM_SETS),
    localparam int unsigned WORDS       = LINE_SIZE / WORD_SIZE,
    localparam int unsigned SEL_W       = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int unsigned WAY_LOG     = $clog2(NUM_WAYS),
    localparam int unsigned WAY_W       = (NUM_WAYS > 1) ? WAY_LOG : 1,
    localparam int unsigned WORD_BITS   = 8 * WORD_SIZE,
    localparam int unsigned LINE_BITS   = 8 * LINE_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [1:0]           i_req_op,
    input  logic [SET_W-1:0]     i_req_set,
    input  logic [TAG_BITS-1:0]  i_req_tag,
    input  logic [SEL_W-1:0]     i_req_wordsel,
    input  logic [WORD_SIZE-1:0] i_req_byteen,
    input  logic [WORD_BITS-1:0] i_req_wword,
    input  logic [LINE_BITS-1:0] i_req_fline,
    output logic                 o_rsp_valid,
    output logic                 o_rsp_hit,
    output logic [WAY_W-1:0]     o_rsp_way,
    output logic [WORD_BITS-1:0] o_rsp_rword,
    output logic                 o_rsp_evict_valid,
    output logic [TAG_BITS-1:0]  o_rsp_evict_tag,
    output logic [LINE_BITS-1:0] o_rsp_evict_line,
    input  logic                 i_flush_start,
    output logic                 o_flush_busy
);

    localparam int unsigned PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;
    localparam logic [1:0] OP_SNOOP = 2'd3;

    typedef enum logic [0:0] {StIdle, StFlush} state_t;

    logic [NUM_WAYS-1:0]  r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0]  r_dirty [NUM_SETS];
    logic [PLRU_W-1:0]    r_plru  [NUM_SETS];
    logic [WAY_W-1:0]     r_rr    [NUM_SETS];
    logic [TAG_BITS-1:0]  r_tag   [NUM_SETS][NUM_WAYS];
    logic [LINE_BITS-1:0] r_data  [NUM_SETS][NUM_WAYS];

    state_t               r_state;
    logic [SET_W-1:0]     r_flush_set;
    logic                 r_flush_busy;

    logic                 r_rsp_valid;
    logic                 r_rsp_hit;
    logic [WAY_W-1:0]     r_rsp_way;
    logic [WORD_BITS-1:0] r_rsp_rword;
    logic                 r_rsp_evict_valid;
    logic [TAG_BITS-1:0]  r_rsp_evict_tag;
    logic [LINE_BITS-1:0] r_rsp_evict_line;

    logic                 w_acc;
    logic                 w_flush_clr;
    logic [NUM_WAYS-1:0]  w_valid_cur;
    logic [NUM_WAYS-1:0]  w_dirty_cur;
    logic [PLRU_W-1:0]    w_plru_cur;
    logic [PLRU_W-1:0]    w_plru_next;
    logic [WAY_W-1:0]     w_rr_cur;
    logic [WAY_W-1:0]     w_rr_next;
    logic [NUM_WAYS-1:0]  w_hit_vec;
    logic                 w_hit;
    logic [WAY_W-1:0]     w_hit_way;
    logic [WAY_W-1:0]     w_plru_leaf;
    logic [WAY_W-1:0]     w_victim;
    logic [WAY_W-1:0]     w_way;
    logic [SEL_W-1:0]     w_sel;
    logic [LINE_BITS-1:0] w_line_cur;
    logic [LINE_BITS-1:0] w_line_new;
    logic [WORD_BITS-1:0] w_word_cur;
    logic [WORD_BITS-1:0] w_word_new;
    logic [WORD_BITS-1:0] w_mask;
    logic [WORD_BITS-1:0] w_rword;
    logic                 w_evict;
    logic                 w_do_write;
    logic                 w_do_fill;
    logic                 w_do_snoop;
    logic                 w_do_touch;

    assign o_req_ready = (r_state == StIdle) && !i_stall && !i_flush_start;
    assign w_acc       = i_req_valid && o_req_ready;
    assign w_flush_clr = (r_state == StFlush) && !i_stall;

    assign w_valid_cur = r_valid[i_req_set];
    assign w_dirty_cur = r_dirty[i_req_set];
    assign w_plru_cur  = r_plru[i_req_set];
    assign w_rr_cur    = r_rr[i_req_set];

    always_comb begin
        w_hit_vec = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_hit_vec[w] = w_valid_cur[w] && (r_tag[i_req_set][w] == i_req_tag);
        end
    end

    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
        end
    end

    assign w_hit = |w_hit_vec;

    // Tree walk: node n has children 2n and 2n+1, bit (n-1) set means the victim lies right.
    always_comb begin
        int unsigned node;
        node = 1;
        for (int unsigned l = 0; l < WAY_LOG; l++) begin
            node = 2 * node + ((((w_plru_cur >> (node - 1)) & 1) != 0) ? 1 : 0);
        end
        w_plru_leaf = WAY_W'(node - NUM_WAYS);
    end

    always_comb begin
        w_victim = (REPL_POLICY == 1) ? w_rr_cur : w_plru_leaf;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!w_valid_cur[w]) w_victim = WAY_W'(w);
        end
        if (NUM_WAYS == 1) w_victim = '0;
    end

    assign w_way     = w_hit ? w_hit_way : w_victim;
    assign w_rr_next = (w_rr_cur == WAY_W'(NUM_WAYS - 1)) ? '0 : w_rr_cur + 1'b1;

    always_comb begin
        int unsigned path;
        int unsigned node;
        w_plru_next = w_plru_cur;
        path        = NUM_WAYS + 32'(w_way);
        node        = 0;
        for (int unsigned l = 0; l < WAY_LOG; l++) begin
            node = path >> (WAY_LOG - l);
            if (((path >> (WAY_LOG - l - 1)) & 1) == 0) begin
                w_plru_next = w_plru_next | (PLRU_W'(1) << (node - 1));
            end else begin
                w_plru_next = w_plru_next & ~(PLRU_W'(1) << (node - 1));
            end
        end
    end

    assign w_sel      = (WORDS > 1) ? i_req_wordsel : '0;
    assign w_line_cur = r_data[i_req_set][w_way];
    assign w_word_cur = w_line_cur[w_sel*WORD_BITS +: WORD_BITS];

    always_comb begin
        w_mask     = '0;
        w_word_new = w_word_cur;
        for (int b = 0; b < WORD_SIZE; b++) begin
            if (i_req_byteen[b]) begin
                w_mask[8*b +: 8]     = 8'hFF;
                w_word_new[8*b +: 8] = i_req_wword[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_line_new = w_line_cur;
        w_line_new[w_sel*WORD_BITS +: WORD_BITS] = w_word_new;
    end

    always_comb begin
        w_rword = '0;
        if (w_hit) begin
            if (i_req_op == OP_READ) begin
                w_rword = w_word_cur & w_mask;
            end else if (i_req_op == OP_WRITE) begin
                w_rword = (WRITE_ENABLE != 0) ? w_word_new : w_word_cur;
            end
        end
    end

    assign w_do_write = w_acc && (i_req_op == OP_WRITE) && w_hit && (WRITE_ENABLE != 0);
    assign w_do_fill  = w_acc && (i_req_op == OP_FILL) && !w_hit;
    assign w_do_snoop = w_acc && (i_req_op == OP_SNOOP) && w_hit;
    assign w_do_touch = (w_acc && w_hit && ((i_req_op == OP_READ) || (i_req_op == OP_WRITE)))
                        || w_do_fill;

    assign w_evict = ((i_req_op == OP_FILL) && !w_hit && w_valid_cur[w_way] && w_dirty_cur[w_way])
                     || ((i_req_op == OP_SNOOP) && w_hit && w_dirty_cur[w_way]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
                r_rr[s]    <= '0;
            end
        end else if (w_flush_clr) begin
            r_valid[r_flush_set] <= '0;
            r_dirty[r_flush_set] <= '0;
            r_plru[r_flush_set]  <= '0;
            r_rr[r_flush_set]    <= '0;
        end else begin
            if (w_do_fill) begin
                r_valid[i_req_set][w_way] <= 1'b1;
                r_dirty[i_req_set][w_way] <= 1'b0;
                r_rr[i_req_set]           <= w_rr_next;
            end
            if (w_do_write) r_dirty[i_req_set][w_way] <= 1'b1;
            if (w_do_snoop) begin
                r_valid[i_req_set][w_way] <= 1'b0;
                r_dirty[i_req_set][w_way] <= 1'b0;
            end
            if (w_do_touch) r_plru[i_req_set] <= w_plru_next;
        end
    end

    // Tag and data contents are qualified by valid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_fill) begin
            r_tag[i_req_set][w_way]  <= i_req_tag;
            r_data[i_req_set][w_way] <= i_req_fline;
        end else if (w_do_write) begin
            r_data[i_req_set][w_way] <= w_line_new;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_flush_set  <= '0;
            r_flush_busy <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_flush_start && !i_stall) begin
                        r_state      <= StFlush;
                        r_flush_set  <= '0;
                        r_flush_busy <= 1'b1;
                    end
                end
                StFlush: begin
                    if (!i_stall) begin
                        if (r_flush_set == SET_W'(NUM_SETS - 1)) begin
                            r_state      <= StIdle;
                            r_flush_busy <= 1'b0;
                        end
                        r_flush_set <= r_flush_set + 1'b1;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_flush_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid       <= 1'b0;
            r_rsp_hit         <= 1'b0;
            r_rsp_way         <= '0;
            r_rsp_rword       <= '0;
            r_rsp_evict_valid <= 1'b0;
            r_rsp_evict_tag   <= '0;
            r_rsp_evict_line  <= '0;
        end else if (!i_stall) begin
            r_rsp_valid       <= w_acc;
            r_rsp_hit         <= w_acc && w_hit;
            r_rsp_way         <= w_acc ? w_way : '0;
            r_rsp_rword       <= w_acc ? w_rword : '0;
            r_rsp_evict_valid <= w_acc && w_evict;
            r_rsp_evict_tag   <= (w_acc && w_evict) ? r_tag[i_req_set][w_way] : '0;
            r_rsp_evict_line  <= (w_acc && w_evict) ? w_line_cur : '0;
        end
    end

    assign o_rsp_valid       = r_rsp_valid;
    assign o_rsp_hit         = r_rsp_hit;
    assign o_rsp_way         = r_rsp_way;
    assign o_rsp_rword       = r_rsp_rword;
    assign o_rsp_evict_valid = r_rsp_evict_valid;
    assign o_rsp_evict_tag   = r_rsp_evict_tag;
    assign o_rsp_evict_line  = r_rsp_evict_line;
    assign o_flush_busy      = r_flush_busy;

    // A tag may be resident in at most one way of a set.
    assert property (@(posedge i_clk) disable iff (!i_rst_n) w_acc |-> $onehot0(w_hit_vec));

endmodule

// File: tb/tb_vx_assoc_tag_data_access.sv
// Randomised bench for vx_assoc_tag_data_access against a timestamp-based reference cache model.
module tb_vx_assoc_tag_data_access;

    localparam int NS = 64;
    localparam int NW = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [5:0]   req_set;
    logic [19:0]  req_tag;
    logic [1:0]   req_wordsel;
    logic [3:0]   req_byteen;
    logic [31:0]  req_wword;
    logic [127:0] req_fline;
    logic         rsp_valid;
    logic         rsp_hit;
    logic [1:0]   rsp_way;
    logic [31:0]  rsp_rword;
    logic         rsp_evict_valid;
    logic [19:0]  rsp_evict_tag;
    logic [127:0] rsp_evict_line;
    logic         flush_start;
    logic         flush_busy;

    vx_assoc_tag_data_access dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_stall           (stall),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_op          (req_op),
        .i_req_set         (req_set),
        .i_req_tag         (req_tag),
        .i_req_wordsel     (req_wordsel),
        .i_req_byteen      (req_byteen),
        .i_req_wword       (req_wword),
        .i_req_fline       (req_fline),
        .o_rsp_valid       (rsp_valid),
        .o_rsp_hit         (rsp_hit),
        .o_rsp_way         (rsp_way),
        .o_rsp_rword       (rsp_rword),
        .o_rsp_evict_valid (rsp_evict_valid),
        .o_rsp_evict_tag   (rsp_evict_tag),
        .o_rsp_evict_line  (rsp_evict_line),
        .i_flush_start     (flush_start),
        .o_flush_busy      (flush_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: replacement tracked by last-touch time per way.
    bit           m_valid [NS][NW];
    bit           m_dirty [NS][NW];
    logic [19:0]  m_tag   [NS][NW];
    logic [127:0] m_data  [NS][NW];
    int unsigned  m_ts    [NS][NW];
    int unsigned  m_now;

    logic         e_valid;
    logic         e_hit;
    int           e_way;
    logic [31:0]  e_rword;
    logic         e_ev;
    logic [19:0]  e_etag;
    logic [127:0] e_eline;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void m_clear();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_ts[s][w]    = 0;
            end
        end
    endfunction

    function automatic int m_find(input int s, input logic [19:0] t);
        for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    // Descend toward whichever half was touched less recently; ties go left.
    function automatic int m_victim(input int s);
        int lo, size, half;
        int unsigned ml, mr;
        for (int w = 0; w < NW; w++) if (!m_valid[s][w]) return w;
        lo   = 0;
        size = NW;
        while (size > 1) begin
            half = size / 2;
            ml   = 0;
            mr   = 0;
            for (int w = 0; w < half; w++) begin
                if (m_ts[s][lo+w] > ml) ml = m_ts[s][lo+w];
                if (m_ts[s][lo+half+w] > mr) mr = m_ts[s][lo+half+w];
            end
            if (ml > mr) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    function automatic void m_touch(input int s, input int w);
        m_now++;
        m_ts[s][w] = m_now;
    endfunction

    function automatic void m_apply(input logic [1:0] op, input int s, input logic [19:0] t,
                                    input int sel, input logic [3:0] be, input logic [31:0] ww,
                                    input logic [127:0] fl);
        int hw, v;
        logic [31:0] word, mask;
        hw = m_find(s, t);
        v  = m_victim(s);
        e_valid = 1;
        e_hit   = (hw >= 0);
        e_way   = e_hit ? hw : v;
        e_rword = '0;
        e_ev    = 0;
        e_etag  = '0;
        e_eline = '0;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        case (op)
            2'd0: if (e_hit) begin
                e_rword = m_data[s][hw][sel*32 +: 32] & mask;
                m_touch(s, hw);
            end
            2'd1: if (e_hit) begin
                word = (m_data[s][hw][sel*32 +: 32] & ~mask) | (ww & mask);
                m_data[s][hw][sel*32 +: 32] = word;
                m_dirty[s][hw] = 1;
                e_rword = word;
                m_touch(s, hw);
            end
            2'd2: if (!e_hit) begin
                if (m_valid[s][v] && m_dirty[s][v]) begin
                    e_ev    = 1;
                    e_etag  = m_tag[s][v];
                    e_eline = m_data[s][v];
                end
                m_tag[s][v]   = t;
                m_data[s][v]  = fl;
                m_valid[s][v] = 1;
                m_dirty[s][v] = 0;
                m_touch(s, v);
            end
            default: if (e_hit) begin
                if (m_dirty[s][hw]) begin
                    e_ev    = 1;
                    e_etag  = m_tag[s][hw];
                    e_eline = m_data[s][hw];
                end
                m_valid[s][hw] = 0;
                m_dirty[s][hw] = 0;
            end
        endcase
    endfunction

    task automatic check_rsp();
        check("rsp_valid", rsp_valid, e_valid);
        if (e_valid) begin
            check("rsp_hit", rsp_hit, e_hit);
            check("rsp_way", rsp_way, e_way[1:0]);
            check("rsp_rword", rsp_rword, e_rword);
            check("rsp_evict_valid", rsp_evict_valid, e_ev);
            check("rsp_evict_tag", rsp_evict_tag, e_etag);
            check("rsp_evict_line", rsp_evict_line, e_eline);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the response checked.
    task automatic req(input logic [1:0] op, input int s, input logic [19:0] t, input int sel,
                       input logic [3:0] be, input logic [31:0] ww, input logic [127:0] fl);
        req_valid   = 1;
        req_op      = op;
        req_set     = s[5:0];
        req_tag     = t;
        req_wordsel = sel[1:0];
        req_byteen  = be;
        req_wword   = ww;
        req_fline   = fl;
        stall       = 0;
        #1 check("req_ready", req_ready, 1'b1);
        m_apply(op, s, t, sel, be, ww, fl);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        check_rsp();
    endtask

    task automatic idle_cycle();
        req_valid = 0;
        @(posedge clk);
        @(negedge clk);
        e_valid = 0;
        check("idle_rsp_valid", rsp_valid, 1'b0);
    endtask

    task automatic stall_cycle();
        stall     = 1;
        req_valid = 1'($urandom);
        req_op    = 2'($urandom);
        req_tag   = 20'($urandom_range(0, 7));
        #1 check("ready_under_stall", req_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        stall     = 0;
        req_valid = 0;
        check_rsp();
    endtask

    task automatic prefill_all();
        for (int s = 0; s < NS; s++) req(2'd2, s, 20'(s % 8 + 100), 0, 4'h0, 32'h0,
                                         {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic read_all_miss();
        for (int s = 0; s < NS; s++) begin
            req(2'd0, s, 20'(s % 8 + 100), 0, 4'hF, 32'h0, 128'h0);
            check("post_flush_miss", rsp_hit, 1'b0);
        end
    endtask

    task automatic run_flush(input int stall_at, input int exp_cycles);
        int cnt;
        flush_start = 1;
        req_valid   = 1;
        req_op      = 2'd0;
        #1 check("ready_with_flush_start", req_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        flush_start = 0;
        req_valid   = 0;
        check("no_rsp_on_flush_start", rsp_valid, 1'b0);
        cnt = 0;
        while (flush_busy && cnt < 200) begin
            cnt++;
            if (cnt == 30) check("ready_mid_flush", req_ready, 1'b0);
            if (cnt == stall_at) stall = 1;
            if (cnt == stall_at + 3) stall = 0;
            @(posedge clk);
            @(negedge clk);
        end
        stall = 0;
        check("flush_busy_cycles", 128'(cnt), 128'(exp_cycles));
        m_clear();
        e_valid = 0;
    endtask

    initial begin
        int cnt, r;
        rst_n = 0; stall = 0; req_valid = 0; flush_start = 0; req_op = 0; req_set = 0;
        req_tag = 0; req_wordsel = 0; req_byteen = 0; req_wword = 0; req_fline = 0;
        m_now = 0;
        m_clear();
        e_valid = 0;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_flush_busy", flush_busy, 1'b0);
        check("reset_rsp_rword", rsp_rword, 32'h0);
        check("reset_evict_valid", rsp_evict_valid, 1'b0);
        @(negedge clk);
        rst_n = 1;
        #1 check("reset_req_ready", req_ready, 1'b1);
        @(negedge clk);

        req(2'd0, 3, 20'h1A, 0, 4'hF, 32'h0, 128'h0);
        check("tp_cold_hit", rsp_hit, 1'b0);
        check("tp_cold_way", rsp_way, 2'd0);
        req(2'd2, 3, 20'h1A, 0, 4'h0, 32'h0, 128'h44444444_33333333_22222222_DDCCBBAA);
        req(2'd0, 3, 20'h1A, 0, 4'b0011, 32'h0, 128'h0);
        check("tp_masked_read", rsp_rword, 32'h0000BBAA);

        for (int t = 1; t <= 4; t++) req(2'd2, 6, 20'(t), 0, 4'h0, 32'h0, 128'(t * 7));
        req(2'd0, 6, 20'd1, 1, 4'hF, 32'h0, 128'h0);
        req(2'd1, 6, 20'd2, 2, 4'hF, 32'hCAFE0002, 128'h0);
        req(2'd2, 6, 20'd9, 0, 4'h0, 32'h0, 128'h9);
        check("tp_plru_victim", rsp_way, 2'd2);
        check("tp_clean_no_evict", rsp_evict_valid, 1'b0);

        for (int t = 1; t <= 3; t++) req(2'd2, 5, 20'(t), 0, 4'h0, 32'h0, 128'(t * 11));
        req(2'd1, 5, 20'd3, 0, 4'b1001, 32'hA5A5A5A5, 128'h0);
        req(2'd2, 5, 20'd4, 0, 4'h0, 32'h0, 128'h44);
        req(2'd0, 5, 20'd1, 0, 4'hF, 32'h0, 128'h0);
        req(2'd1, 5, 20'd2, 3, 4'hF, 32'h12345678, 128'h0);
        req(2'd2, 5, 20'd9, 0, 4'h0, 32'h0, 128'h99);
        check("tp_dirty_victim_way", rsp_way, 2'd2);
        check("tp_dirty_evict", rsp_evict_valid, 1'b1);
        check("tp_dirty_evict_tag", rsp_evict_tag, 20'd3);
        req(2'd3, 5, 20'd2, 0, 4'h0, 32'h0, 128'h0);
        check("tp_snoop_evict", rsp_evict_valid, 1'b1);
        req(2'd0, 5, 20'd2, 0, 4'hF, 32'h0, 128'h0);
        check("tp_snoop_then_miss", rsp_hit, 1'b0);

        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) idle_cycle();
            else if (r == 1 && e_valid) stall_cycle();
            else req(2'($urandom), int'($urandom_range(0, 3)), 20'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), 4'($urandom), $urandom,
                     {$urandom, $urandom, $urandom, $urandom});
        end

        prefill_all();
        run_flush(0, 64);
        read_all_miss();

        prefill_all();
        run_flush(20, 67);
        read_all_miss();

        prefill_all();
        flush_start = 1;
        @(posedge clk);
        @(negedge clk);
        flush_start = 0;
        cnt = 0;
        while (flush_busy && cnt < 10) begin
            cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        check("busy_before_reset", flush_busy, 1'b1);
        #2 rst_n = 0;
        #1 check("busy_cleared_by_reset", flush_busy, 1'b0);
        check("rsp_cleared_by_reset", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1;
        #1 check("ready_after_reset", req_ready, 1'b1);
        m_clear();
        e_valid = 0;
        @(negedge clk);
        read_all_miss();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
